// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the wide ALU: opcode and operand-select
//                enums, FSM state encoding, and flag bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_SRL  = 4'h3,
        OP_SLL  = 4'h4,
        OP_ROR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_NOT  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NAND = 4'hB,
        OP_NOR  = 4'hC,
        OP_XNOR = 4'hD,
        OP_INC  = 4'hE,
        OP_DEC  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        MOVI_REG_B = 2'b00,
        MOVI_MEM   = 2'b01,
        MOVI_IMM   = 2'b10,
        MOVI_ZERO  = 2'b11
    } movi_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RES      = 3'd1,
        MUL_BUSY = 3'd2,
        MUL_LO   = 3'd3,
        MUL_HI   = 3'd4
    } state_e;

    // FLAGS layout is {V,C,N,Z}
    localparam int c_FLAG_Z   = 0;
    localparam int c_FLAG_N   = 1;
    localparam int c_FLAG_C   = 2;
    localparam int c_FLAG_V   = 3;
    localparam int c_NUM_FLAGS = 4;

endpackage
`default_nettype wire

// File: rtl/alu_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_pipe
//  Description : Unsigned WIDTH x WIDTH multiplier with MUL_LAT register
//                stages. o_done pulses for one cycle when o_product holds
//                the product of the operands captured with i_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_pipe #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    logic [MUL_LAT-1:0] r_vld;
    logic [2*WIDTH-1:0] r_prod [MUL_LAT];
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;

    assign w_a_ext = {{WIDTH{1'b0}}, i_a};
    assign w_b_ext = {{WIDTH{1'b0}}, i_b};

    // First stage: multiply the incoming operands when a multiply starts
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld[0]  <= 1'b0;
            r_prod[0] <= '0;
        end else begin
            r_vld[0] <= i_start;
            if (i_start) begin
                r_prod[0] <= w_a_ext * w_b_ext;
            end
        end
    end

    // Remaining stages delay product and valid together; retiming spreads the multiply
    for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_stage
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_vld[gi]  <= 1'b0;
                r_prod[gi] <= '0;
            end else begin
                r_vld[gi]  <= r_vld[gi-1];
                r_prod[gi] <= r_prod[gi-1];
            end
        end
    end

    assign o_done    = r_vld[MUL_LAT-1];
    assign o_product = r_prod[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/alu_wide.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wide
//  Description : WIDTH-bit 16-opcode ALU with operand-B mux, pipelined
//                multiplier delivering two result beats (low, high), and a
//                VLD/ACK output handshake that holds results under
//                backpressure. Define ALU_FLAGS_EN to add the FLAGS port
//                ({V,C,N,Z}) and its flag registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wide
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic [3:0]       OP,
    input  logic [1:0]       MOVI,
    input  logic [WIDTH-1:0] REG_A,
    input  logic [WIDTH-1:0] REG_B,
    input  logic [WIDTH-1:0] MEM,
    input  logic [WIDTH-1:0] IMM,
    input  logic             ACK,
    output logic [WIDTH-1:0] DATA,
    output logic             RDY,
    output logic             VLD,
    output logic             LAST
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       FLAGS
`endif
);

    localparam int c_MSB = WIDTH - 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2*WIDTH-1:0] r_out;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_res;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_vld;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;

    assign w_accept = ACT && (r_state == IDLE);
    assign w_is_mul = (op_e'(OP) == OP_MUL);

    // Operand-B source select
    always_comb begin
        w_b = '0;
        case (movi_e'(MOVI))
            MOVI_REG_B: w_b = REG_B;
            MOVI_MEM:   w_b = MEM;
            MOVI_IMM:   w_b = IMM;
            default:    w_b = '0;
        endcase
    end

    // Single-cycle result for every opcode except multiply
    always_comb begin
        w_res = '0;
        case (op_e'(OP))
            OP_ADD:  w_res = REG_A + w_b;
            OP_SUB:  w_res = REG_A - w_b;
            OP_SRL:  w_res = {1'b0, w_b[c_MSB:1]};
            OP_SLL:  w_res = {w_b[c_MSB-1:0], 1'b0};
            OP_ROR:  w_res = {w_b[0], w_b[c_MSB:1]};
            OP_ROL:  w_res = {w_b[c_MSB-1:0], w_b[c_MSB]};
            OP_NOT:  w_res = ~w_b;
            OP_AND:  w_res = REG_A & w_b;
            OP_OR:   w_res = REG_A | w_b;
            OP_XOR:  w_res = REG_A ^ w_b;
            OP_NAND: w_res = ~(REG_A & w_b);
            OP_NOR:  w_res = ~(REG_A | w_b);
            OP_XNOR: w_res = ~(REG_A ^ w_b);
            OP_INC:  w_res = w_b + 1'b1;
            OP_DEC:  w_res = w_b - 1'b1;
            default: w_res = '0;
        endcase
    end

    alu_mul_pipe #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .CLK       (CLK),
        .RST       (RST),
        .i_start   (w_accept && w_is_mul),
        .i_a       (REG_A),
        .i_b       (w_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: each result beat advances only on ACK
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_nxt = w_is_mul ? MUL_BUSY : RES;
            RES:      if (ACK) w_state_nxt = IDLE;
            MUL_BUSY: if (w_mul_done) w_state_nxt = MUL_LO;
            MUL_LO:   if (ACK) w_state_nxt = MUL_HI;
            MUL_HI:   if (ACK) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Result holding register; only loaded on accept or product arrival so beats stay stable
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_out <= {{WIDTH{1'b0}}, w_res};
        end else if ((r_state == MUL_BUSY) && w_mul_done) begin
            r_out <= w_mul_prod;
        end
    end

    // Handshake outputs; RST masks VLD combinationally so no beat leaks in the reset cycle
    always_comb begin
        w_vld = !RST && ((r_state == RES) || (r_state == MUL_LO) || (r_state == MUL_HI));
        VLD   = w_vld;
        RDY   = (r_state == IDLE);
        LAST  = w_vld && ((r_state == RES) || (r_state == MUL_HI));
        DATA  = '0;
        if (w_vld) begin
            DATA = (r_state == MUL_HI) ? r_out[2*WIDTH-1:WIDTH] : r_out[WIDTH-1:0];
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags_op;
    logic [3:0] w_flags_mul;
    logic       w_c;
    logic       w_v;

    // Carry/borrow and signed overflow for the single-cycle opcodes
    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        case (op_e'(OP))
            OP_ADD: begin
                w_c = (REG_A[c_MSB] & w_b[c_MSB]) | ((REG_A[c_MSB] | w_b[c_MSB]) & ~w_res[c_MSB]);
                w_v = (REG_A[c_MSB] == w_b[c_MSB]) && (w_res[c_MSB] != REG_A[c_MSB]);
            end
            OP_SUB: begin
                w_c = (REG_A < w_b);
                w_v = (REG_A[c_MSB] != w_b[c_MSB]) && (w_res[c_MSB] != REG_A[c_MSB]);
            end
            OP_INC: begin
                w_c = &w_b;
                w_v = !w_b[c_MSB] && w_res[c_MSB];
            end
            OP_DEC: begin
                w_c = (w_b == '0);
                w_v = w_b[c_MSB] && !w_res[c_MSB];
            end
            OP_SRL, OP_ROR: w_c = w_b[0];
            OP_SLL, OP_ROL: w_c = w_b[c_MSB];
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    // Flag vectors for both result paths; a non-zero high half counts as carry and overflow
    always_comb begin
        w_flags_op            = '0;
        w_flags_op[c_FLAG_Z]  = (w_res == '0);
        w_flags_op[c_FLAG_N]  = w_res[c_MSB];
        w_flags_op[c_FLAG_C]  = w_c;
        w_flags_op[c_FLAG_V]  = w_v;
        w_flags_mul           = '0;
        w_flags_mul[c_FLAG_Z] = (w_mul_prod == '0);
        w_flags_mul[c_FLAG_N] = w_mul_prod[2*WIDTH-1];
        w_flags_mul[c_FLAG_C] = (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
        w_flags_mul[c_FLAG_V] = (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
    end

    // Flags load alongside the result and stay put for every beat of the operation
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_flags <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_flags <= w_flags_op;
        end else if ((r_state == MUL_BUSY) && w_mul_done) begin
            r_flags <= w_flags_mul;
        end
    end

    assign FLAGS = r_flags;
`endif

endmodule
`default_nettype wire
